// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: opcodes, command payload and driver FSM states.
package alu_pkg;

  localparam int unsigned SEL_W  = 4;
  localparam int unsigned OPND_W = 8;
  localparam int unsigned RES_W  = 16;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } drv_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head is visible combinationally, a push is poppable the next cycle.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_cmd_t din,
  input  logic     pop,
  output alu_cmd_t head_c,
  output logic     full_c,
  output logic     empty_c
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  alu_cmd_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push_ok;
  logic            pop_ok;

  assign full_c  = (count == CW'(FIFO_DEPTH));
  assign empty_c = (count == '0);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands, drives the registered ALU, and returns each Z on a valid/ready stream.
// Optional counters enabled by ALU_CMD_DRIVER_STATS_EN.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_z,
  output logic [SEL_W-1:0]  rsp_sel,
  output logic              busy
`ifdef ALU_CMD_DRIVER_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

  drv_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  alu_cmd_t          alu_q, alu_nxt;
  logic              rsp_valid_nxt;
  logic [RES_W-1:0]  rsp_z_nxt;
  logic [SEL_W-1:0]  rsp_sel_nxt;
  logic              pop_c;
  alu_cmd_t          head_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  alu_cmd_t          cmd_in;

  assign cmd_in    = '{sel: cmd_sel, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full_c;
  assign busy      = (state != IDLE) || !fifo_empty_c;
  assign alu_sel   = alu_q.sel;
  assign alu_a     = alu_q.a;
  assign alu_b     = alu_q.b;

  alu_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cmd_valid),
    .din    (cmd_in),
    .pop    (pop_c),
    .head_c (head_c),
    .full_c (fifo_full_c),
    .empty_c(fifo_empty_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_sel   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      alu_q     <= alu_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_z     <= rsp_z_nxt;
      rsp_sel   <= rsp_sel_nxt;
    end
  end

  // Next-state: issue from FIFO, count out ALU latency, hold response until accepted.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    alu_nxt       = alu_q;
    rsp_valid_nxt = rsp_valid;
    rsp_z_nxt     = rsp_z;
    rsp_sel_nxt   = rsp_sel;
    pop_c         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty_c) begin
          pop_c     = 1'b1;
          alu_nxt   = head_c;
          cnt_nxt   = CNT_W'(ALU_LAT);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          rsp_z_nxt     = alu_z;
          rsp_sel_nxt   = alu_q.sel;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          if (!fifo_empty_c) begin
            pop_c     = 1'b1;
            alu_nxt   = head_c;
            cnt_nxt   = CNT_W'(ALU_LAT);
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_CMD_DRIVER_STATS_EN
  // Saturating handshake and stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (rsp_valid && rsp_ready && (stat_ops != 16'hFFFF))
        stat_ops <= stat_ops + 16'd1;
      if ((state == RESP) && !rsp_ready && (stat_stall != 16'hFFFF))
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule
